gpu_operand_collector: RTL

GPU_OPERAND_COLLECTOR -- requirements
Module: gpu_operand_collector

---
 rtl/gpu_operand_collector.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gpu_operand_collector.sv
// rtl/gpu_operand_collector.sv - gathers up to three source operands from four single-ported register banks
module gpu_operand_collector #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [5:0]                  in_warp,
    input  logic [4:0]                  in_src0,
    input  logic [4:0]                  in_src1,
    input  logic [4:0]                  in_src2,
    input  logic [2:0]                  in_src_mask,
    output logic [NUM_BANKS-1:0]        bank_rd_en,
    output logic [NUM_BANKS*9-1:0]      bank_rd_addr,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [5:0]                  out_warp,
    output logic [DATA_W-1:0]           out_op0,
    output logic [DATA_W-1:0]           out_op1,
    output logic [DATA_W-1:0]           out_op2
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              ready_en;
    logic              accept;

    logic [5:0]        warp_q;
    logic [4:0]        src_q      [3];
    logic [2:0]        pend_q;
    logic [2:0]        pend_next;
    logic [2:0]        ret_valid_q;
    logic [1:0]        ret_bank_q [3];
    logic [DATA_W-1:0] op_q       [3];

    logic [1:0]        op_bank    [3];
    logic [8:0]        op_addr    [3];
    logic [3:0]        grant_en;
    logic [8:0]        grant_addr [4];
    logic [2:0]        sat;
    logic [DATA_W-1:0] rd_data_b  [4];

    assign accept = in_valid && in_ready;

    genvar gb;
    generate
        for (gb = 0; gb < 4; gb++) begin : g_bank
            assign rd_data_b[gb]            = bank_rd_data[gb*DATA_W +: DATA_W];
            assign bank_rd_addr[gb*9 +: 9]  = grant_addr[gb];
        end
    endgenerate

    // Bank is the register index rotated by the warp so warps spread across banks
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            op_bank[k] = src_q[k][1:0] + warp_q[1:0];
            op_addr[k] = {warp_q, src_q[k][4:2]};
        end
    end

    // Arbitration: first pending operand per bank wins; same-address operands ride along
    always_comb begin
        grant_en   = '0;
        sat        = '0;
        for (int b = 0; b < 4; b++) grant_addr[b] = '0;
        if (state == S_ISSUE) begin
            for (int k = 0; k < 3; k++) begin
                if (pend_q[k]) begin
                    if (!grant_en[op_bank[k]]) begin
                        grant_en[op_bank[k]]   = 1'b1;
                        grant_addr[op_bank[k]] = op_addr[k];
                        sat[k]                 = 1'b1;
                    end else if (grant_addr[op_bank[k]] == op_addr[k]) begin
                        sat[k] = 1'b1;
                    end
                end
            end
        end
        pend_next = pend_q & ~sat;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = (in_src_mask != 3'b000) ? S_ISSUE : S_DONE;
            S_ISSUE: if (pend_next == 3'b000) state_next = S_WAIT;
            S_WAIT:  state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready   = (state == S_IDLE) && ready_en;
        out_valid  = (state == S_DONE);
        bank_rd_en = grant_en;
    end

    // Holds in_ready low until the first clock edge after reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // Request capture, pending tracking and return-data capture one cycle after each read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warp_q      <= '0;
            pend_q      <= '0;
            ret_valid_q <= '0;
            for (int k = 0; k < 3; k++) begin
                src_q[k]      <= '0;
                ret_bank_q[k] <= '0;
                op_q[k]       <= '0;
            end
        end else begin
            if (accept) begin
                warp_q   <= in_warp;
                src_q[0] <= in_src0;
                src_q[1] <= in_src1;
                src_q[2] <= in_src2;
                pend_q   <= in_src_mask;
                for (int k = 0; k < 3; k++) op_q[k] <= '0;
            end else if (state == S_ISSUE) begin
                pend_q <= pend_next;
            end

            if (state == S_ISSUE) begin
                ret_valid_q <= sat;
                for (int k = 0; k < 3; k++) ret_bank_q[k] <= op_bank[k];
            end else begin
                ret_valid_q <= '0;
            end

            for (int k = 0; k < 3; k++) begin
                if (ret_valid_q[k]) op_q[k] <= rd_data_b[ret_bank_q[k]];
            end
        end
    end

    assign out_warp = warp_q;
    assign out_op0  = op_q[0];
    assign out_op1  = op_q[1];
    assign out_op2  = op_q[2];

endmodule
